// File: rtl/dmem_lsu.sv
// Load/store unit between a single-outstanding core request port and a 16-bit
// big-endian byte-lane data RAM with configurable read latency.
module dmem_lsu #(
    parameter int P_RD_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic        i_req_size,
    input  logic        i_req_signed,
    input  logic [9:0]  i_req_addr,
    input  logic [15:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [15:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_mem_en,
    output logic        o_mem_we_h,
    output logic        o_mem_we_l,
    output logic [9:1]  o_mem_addr,
    output logic [7:0]  o_mem_din_h,
    output logic [7:0]  o_mem_din_l,
    input  logic [7:0]  i_mem_dout_h,
    input  logic [7:0]  i_mem_dout_l,
    output logic [7:0]  o_err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_WAIT = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    state_t      state_q;
    logic        req_we_q;
    logic        req_size_q;
    logic        req_signed_q;
    logic        req_lane_q;
    logic [1:0]  lat_cnt_q;
    logic        ready_q;
    logic        mem_en_q;
    logic        mem_we_h_q;
    logic        mem_we_l_q;
    logic [8:0]  mem_addr_q;
    logic [7:0]  mem_din_h_q;
    logic [7:0]  mem_din_l_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [7:0]  err_cnt_q;

    logic        accept_s;
    logic        misaligned_s;
    logic [7:0]  lane_s;
    logic [15:0] load_data_d;

    assign accept_s     = i_req_valid & ready_q;
    assign misaligned_s = i_req_size & i_req_addr[0];

    // Format RAM read data: address bit 0 clear selects the high (big-endian) lane.
    always_comb begin
        lane_s      = 8'h00;
        load_data_d = 16'h0000;
        if (req_size_q) begin
            load_data_d = {i_mem_dout_h, i_mem_dout_l};
        end else begin
            lane_s = req_lane_q ? i_mem_dout_l : i_mem_dout_h;
            if (req_signed_q) begin
                load_data_d = {{8{lane_s[7]}}, lane_s};
            end else begin
                load_data_d = {8'h00, lane_s};
            end
        end
    end

    // Request FSM with all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            req_we_q     <= 1'b0;
            req_size_q   <= 1'b0;
            req_signed_q <= 1'b0;
            req_lane_q   <= 1'b0;
            lat_cnt_q    <= 2'd0;
            ready_q      <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_h_q   <= 1'b0;
            mem_we_l_q   <= 1'b0;
            mem_addr_q   <= 9'd0;
            mem_din_h_q  <= 8'h00;
            mem_din_l_q  <= 8'h00;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 16'h0000;
            rsp_err_q    <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept_s) begin
                        ready_q      <= 1'b0;
                        req_we_q     <= i_req_we;
                        req_size_q   <= i_req_size;
                        req_signed_q <= i_req_signed;
                        req_lane_q   <= i_req_addr[0];
                        mem_addr_q   <= i_req_addr[9:1];
                        if (misaligned_s) begin
                            state_q     <= S_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 16'h0000;
                            if (err_cnt_q != 8'hFF) begin
                                err_cnt_q <= err_cnt_q + 8'd1;
                            end
                        end else begin
                            state_q     <= S_MEM;
                            mem_en_q    <= 1'b1;
                            mem_we_h_q  <= i_req_we & (i_req_size | ~i_req_addr[0]);
                            mem_we_l_q  <= i_req_we & (i_req_size | i_req_addr[0]);
                            // Byte stores replicate onto both lanes; the enables pick one.
                            mem_din_h_q <= i_req_size ? i_req_wdata[15:8] : i_req_wdata[7:0];
                            mem_din_l_q <= i_req_wdata[7:0];
                        end
                    end
                end
                S_MEM: begin
                    mem_en_q   <= 1'b0;
                    mem_we_h_q <= 1'b0;
                    mem_we_l_q <= 1'b0;
                    if (req_we_q) begin
                        state_q     <= S_RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= 16'h0000;
                        rsp_err_q   <= 1'b0;
                    end else begin
                        state_q   <= S_WAIT;
                        lat_cnt_q <= 2'(P_RD_LAT - 1);
                    end
                end
                S_WAIT: begin
                    if (lat_cnt_q == 2'd0) begin
                        state_q     <= S_RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= load_data_d;
                        rsp_err_q   <= 1'b0;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 2'd1;
                    end
                end
                S_RSP: begin
                    if (i_rsp_ready) begin
                        state_q     <= S_IDLE;
                        ready_q     <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 16'h0000;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    ready_q     <= 1'b0;
                    mem_en_q    <= 1'b0;
                    mem_we_h_q  <= 1'b0;
                    mem_we_l_q  <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready = ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_mem_en    = mem_en_q;
    assign o_mem_we_h  = mem_we_h_q;
    assign o_mem_we_l  = mem_we_l_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_din_h = mem_din_h_q;
    assign o_mem_din_l = mem_din_l_q;
    assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Table-driven bench for dmem_lsu with a byte-lane RAM model, a response
// scoreboard queue and an expected-strobe queue for the RAM port.
module tb_dmem_lsu;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic        i_req_size;
    logic        i_req_signed;
    logic [9:0]  i_req_addr;
    logic [15:0] i_req_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [15:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_mem_en;
    logic        o_mem_we_h;
    logic        o_mem_we_l;
    logic [9:1]  o_mem_addr;
    logic [7:0]  o_mem_din_h;
    logic [7:0]  o_mem_din_l;
    logic [7:0]  i_mem_dout_h;
    logic [7:0]  i_mem_dout_l;
    logic [7:0]  o_err_cnt;

    always #5 clk = ~clk;

    dmem_lsu #(.P_RD_LAT(LAT)) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_size   (i_req_size),
        .i_req_signed (i_req_signed),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err),
        .o_mem_en     (o_mem_en),
        .o_mem_we_h   (o_mem_we_h),
        .o_mem_we_l   (o_mem_we_l),
        .o_mem_addr   (o_mem_addr),
        .o_mem_din_h  (o_mem_din_h),
        .o_mem_din_l  (o_mem_din_l),
        .i_mem_dout_h (i_mem_dout_h),
        .i_mem_dout_l (i_mem_dout_l),
        .o_err_cnt    (o_err_cnt)
    );

    // Data RAM model, read latency of one cycle from the enable edge.
    logic [7:0] ram_h [512];
    logic [7:0] ram_l [512];
    always @(posedge clk) begin
        if (o_mem_en) begin
            if (o_mem_we_h) ram_h[o_mem_addr] <= o_mem_din_h;
            if (o_mem_we_l) ram_l[o_mem_addr] <= o_mem_din_l;
            i_mem_dout_h <= ram_h[o_mem_addr];
            i_mem_dout_l <= ram_l[o_mem_addr];
        end
    end

    typedef struct {
        logic        we;
        logic        size;
        logic        sgn;
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          hold;
    } vec_t;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        logic [8:0] addr;
        logic       we_h;
        logic       we_l;
        logic [7:0] din_h;
        logic [7:0] din_l;
    } stb_t;

    vec_t vecs[$];
    rsp_t sb_q[$];
    stb_t st_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_err_cnt = 0;
    bit   mon_on = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic size, input logic sgn,
                                input logic [9:0] addr, input logic [15:0] wdata,
                                input logic [15:0] exp_rdata, input logic exp_err,
                                input int hold);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.hold = hold;
        return v;
    endfunction

    task automatic chk_all_zero(input string nm);
        chk(nm, {o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_mem_en, o_mem_we_h,
                 o_mem_we_l, o_mem_addr, o_mem_din_h, o_mem_din_l, o_err_cnt}, 64'd0);
    endtask

    // Expected RAM-port strobes for an aligned request, from the lane rules.
    task automatic push_strobe(input vec_t v);
        stb_t s;
        s.addr  = v.addr[9:1];
        s.din_l = v.wdata[7:0];
        if (v.size) begin
            s.we_h  = v.we;
            s.we_l  = v.we;
            s.din_h = v.wdata[15:8];
        end else begin
            s.we_h  = v.we && (v.addr[0] == 1'b0);
            s.we_l  = v.we && (v.addr[0] == 1'b1);
            s.din_h = v.wdata[7:0];
        end
        st_q.push_back(s);
    endtask

    // RAM-port monitor: every enable pulse must match one expected strobe.
    always @(negedge clk) begin
        if (mon_on && i_rst_n) begin
            if (o_mem_en) begin
                if (st_q.size() == 0) begin
                    chk("unexpected_mem_en", {63'd0, o_mem_en}, 64'd0);
                end else begin
                    stb_t s;
                    s = st_q.pop_front();
                    chk("mem_addr", {55'd0, o_mem_addr}, {55'd0, s.addr});
                    chk("mem_we", {62'd0, o_mem_we_h, o_mem_we_l}, {62'd0, s.we_h, s.we_l});
                    if (s.we_h) chk("mem_din_h", {56'd0, o_mem_din_h}, {56'd0, s.din_h});
                    if (s.we_l) chk("mem_din_l", {56'd0, o_mem_din_l}, {56'd0, s.din_l});
                end
            end else if (o_mem_we_h || o_mem_we_l) begin
                chk("we_without_en", {62'd0, o_mem_we_h, o_mem_we_l}, 64'd0);
            end
        end
    end

    task automatic run_txn(input vec_t v);
        int   n;
        int   exp_n;
        rsp_t r;
        bit   mis;
        mis = v.size && v.addr[0];
        @(negedge clk);
        n = 0;
        while (o_req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("ready_timeout", {63'd0, o_req_ready}, 64'd1);
            return;
        end
        i_req_valid  = 1'b1;
        i_req_we     = v.we;
        i_req_size   = v.size;
        i_req_signed = v.sgn;
        i_req_addr   = v.addr;
        i_req_wdata  = v.wdata;
        r.rdata = v.exp_rdata;
        r.err   = v.exp_err;
        sb_q.push_back(r);
        if (mis) begin
            exp_err_cnt = (exp_err_cnt < 255) ? exp_err_cnt + 1 : 255;
            exp_n = 1;
        end else begin
            push_strobe(v);
            exp_n = v.we ? 2 : 2 + LAT;
        end
        @(posedge clk);
        @(negedge clk);
        // Request fields churn while busy; none of it may be taken.
        i_req_we     = 1'($urandom);
        i_req_size   = 1'($urandom);
        i_req_signed = 1'($urandom);
        i_req_addr   = 10'($urandom);
        i_req_wdata  = 16'($urandom);
        n = 1;
        while (o_rsp_valid !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (n >= 12) begin
            chk("rsp_timeout", {63'd0, o_rsp_valid}, 64'd1);
            void'(sb_q.pop_front());
            i_req_valid = 1'b0;
            return;
        end
        chk("rsp_latency", 64'(n), 64'(exp_n));
        for (int h = 0; h < v.hold; h++) begin
            chk("hold_valid", {63'd0, o_rsp_valid}, 64'd1);
            chk("hold_ready", {63'd0, o_req_ready}, 64'd0);
            chk("hold_rdata", {48'd0, o_rsp_rdata}, {48'd0, sb_q[0].rdata});
            chk("hold_err", {63'd0, o_rsp_err}, {63'd0, sb_q[0].err});
            @(negedge clk);
        end
        r = sb_q.pop_front();
        chk("rsp_rdata", {48'd0, o_rsp_rdata}, {48'd0, r.rdata});
        chk("rsp_err", {63'd0, o_rsp_err}, {63'd0, r.err});
        i_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_rsp_ready = 1'b0;
        i_req_valid = 1'b0;
        chk("retire_valid", {63'd0, o_rsp_valid}, 64'd0);
        chk("retire_ready", {63'd0, o_req_ready}, 64'd1);
        chk("err_cnt", {56'd0, o_err_cnt}, 64'(exp_err_cnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          we    size  sgn   addr      wdata     rdata     err   hold
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 10'd256,  16'hABCD, 16'h0000, 1'b0, 0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 10'd256,  16'h0000, 16'hABCD, 1'b0, 3));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 10'd257,  16'h0000, 16'hFFCD, 1'b0, 0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 10'd256,  16'h0000, 16'h00AB, 1'b0, 1));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 10'd258,  16'h3C00, 16'h0000, 1'b0, 0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 10'd259,  16'h125A, 16'h0000, 1'b0, 2));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 10'd258,  16'h0000, 16'h3C5A, 1'b0, 0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 10'h101,  16'h0000, 16'h0000, 1'b1, 3));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 10'd4,    16'h8001, 16'h0000, 1'b0, 0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 10'd4,    16'h0000, 16'h0080, 1'b0, 0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 10'd4,    16'h0000, 16'hFF80, 1'b0, 0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 10'd5,    16'h0000, 16'h0001, 1'b0, 0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 10'd4,    16'hFF77, 16'h0000, 1'b0, 0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 10'd4,    16'h0000, 16'h7701, 1'b0, 0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 10'd7,    16'h1234, 16'h0000, 1'b1, 0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 10'd1022, 16'hFFEE, 16'h0000, 1'b0, 0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 10'd1022, 16'h0000, 16'hFFEE, 1'b0, 0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 10'd1023, 16'h0000, 16'hFFEE, 1'b0, 0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 10'd1022, 16'h0000, 16'h00FF, 1'b0, 0));

        i_rst_n      = 1'b0;
        i_req_valid  = 1'b0;
        i_req_we     = 1'b0;
        i_req_size   = 1'b0;
        i_req_signed = 1'b0;
        i_req_addr   = 10'd0;
        i_req_wdata  = 16'd0;
        i_rsp_ready  = 1'b0;

        #22;
        chk_all_zero("reset_outputs");
        @(negedge clk);
        i_rst_n = 1'b1;
        mon_on  = 1'b1;
        chk("ready_before_edge", {63'd0, o_req_ready}, 64'd0);
        @(negedge clk);
        chk("ready_after_release", {63'd0, o_req_ready}, 64'd1);

        foreach (vecs[i]) run_txn(vecs[i]);

        // Saturation of the misaligned-request counter.
        for (int i = 0; i < 300; i++) begin
            logic [9:0] a;
            a = 10'($urandom_range(0, 1023)) | 10'd1;
            run_txn(mk(1'($urandom), 1'b1, 1'b0, a, 16'($urandom), 16'h0000, 1'b1, 0));
        end
        chk("err_cnt_saturated", {56'd0, o_err_cnt}, 64'd255);

        // Reset asserted while a load sits in WAIT.
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_size  = 1'b1;
        i_req_addr  = 10'd256;
        push_strobe(mk(1'b0, 1'b1, 1'b0, 10'd256, 16'h0000, 16'h0000, 1'b0, 0));
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;
        chk("abort_mem_cycle", {63'd0, o_mem_en}, 64'd1);
        @(negedge clk);
        chk("abort_in_wait", {62'd0, o_mem_en, o_rsp_valid}, 64'd0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset_outputs");
        exp_err_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            chk("no_rsp_in_reset", {63'd0, o_rsp_valid}, 64'd0);
        end
        i_rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_rsp_after_abort", {63'd0, o_rsp_valid}, 64'd0);
        end
        run_txn(mk(1'b0, 1'b1, 1'b0, 10'd256, 16'h0000, 16'hABCD, 1'b0, 0));

        chk("strobes_drained", 64'(st_q.size()), 64'd0);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter P_RD_LAT, default 1, meaning data-RAM read latency in cycles from the enable edge to valid i_mem_dout (legal 1..2).
REQ-002 SHALL have ports as follows; one clock; reset is asynchronous and active-low:
  i_clk  in  1  clock, all state on rising edge.
  i_rst_n  in  1  asynchronous active-low reset.
  i_req_valid  in  1  core request valid.
  o_req_ready  out  1  unit can accept request.
  i_req_we  in  1  1 = store, 0 = load.
  i_req_size  in  1  0 = byte, 1 = 16-bit word.
  i_req_signed  in  1  sign-extend byte loads.
  i_req_addr  in  10  byte address.
  i_req_wdata  in  16  store data.
  o_rsp_valid  out  1  response valid.
  i_rsp_ready  in  1  core accepts response.
  o_rsp_rdata  out  16  load data; 0 for stores and errors.
  o_rsp_err  out  1  misaligned word access.
  o_mem_en  out  1  RAM enable.
  o_mem_we_h / o_mem_we_l  out  1 each  RAM high/low byte write enables.
  o_mem_addr  out  9 [9:1]  RAM word address.
  o_mem_din_h / o_mem_din_l  out  8 each  RAM write bytes.
  i_mem_dout_h / i_mem_dout_l  in  8 each  RAM read bytes.
  o_err_cnt  out  8  saturating count of misaligned requests.

Function
REQ-003 SHALL use big-endian byte lanes: i_req_addr[0]=0 selects the high byte, and i_req_addr[0]=1 selects the low byte; o_mem_addr = i_req_addr[9:1].
REQ-004 SHALL implement FSM states IDLE, MEM, WAIT, and RSP; o_req_ready=1 only in IDLE.
REQ-005 SHALL accept a request on a rising edge with i_req_valid and o_req_ready both high (edge E0), and SHALL register all request fields at E0.
REQ-006 For an aligned access, the FSM SHALL go IDLE->MEM at E0; in the MEM cycle, o_mem_en=1 with registered address, write enables, and data, for exactly one cycle.
REQ-007 Word store SHALL drive o_mem_we_h=o_mem_we_l=1, din_h=wdata[15:8], din_l=wdata[7:0].
REQ-008 Byte store SHALL replicate wdata[7:0] onto both din lanes, with o_mem_we_h=~addr[0] and o_mem_we_l=addr[0].
REQ-009 A load SHALL hold both write enables at 0.
REQ-010 A store SHALL transition MEM->RSP at E1; o_rsp_valid is asserted in the cycle after E1, with rdata=0 and err=0.
REQ-011 A load SHALL transition MEM->WAIT; the WAIT state uses a latency counter that captures i_mem_dout at edge E(1+P_RD_LAT), then transitions to RSP.
REQ-012 Word load data SHALL be {dout_h, dout_l}.
REQ-013 Byte load data SHALL be the selected lane, zero-extended, or sign-extended when i_req_signed=1.
REQ-014 A misaligned request (size=1, addr[0]=1) SHALL go IDLE->RSP at E0 with err=1 and rdata=0, SHALL generate no o_mem_en, and SHALL increment o_err_cnt, saturating at 255.
REQ-015 In RSP, o_rsp_valid, o_rsp_rdata, and o_rsp_err SHALL remain stable until an edge with i_rsp_ready=1; the FSM then transitions RSP->IDLE and o_rsp_valid deasserts.
REQ-016 A new request SHALL never be accepted in the same edge as response retirement; the unit is single-outstanding.
REQ-017 o_mem_en and the write enables SHALL be 0 in all states except MEM.
REQ-018 i_req_* changes while o_req_ready=0 SHALL have no effect.

Reset
REQ-019 i_rst_n=0 SHALL asynchronously force state IDLE and set every output to 0, including o_req_ready, o_mem_* strobes, o_rsp_*, and o_err_cnt.
REQ-020 o_req_ready SHALL rise in the first cycle after i_rst_n deasserts.
REQ-021 Reset asserted mid-operation SHALL abort the operation with no response, and the mem strobes SHALL drop immediately.

Verification
REQ-022 Word store 0xABCD at byte addr 256, then word load at 256 -> one MEM cycle with o_mem_addr=128, we_h=we_l=1, din 0xAB/0xCD; the load returns rdata=0xABCD, err=0, with o_rsp_valid 2 cycles after acceptance (P_RD_LAT=1).
REQ-023 After REQ-022, byte load at addr 257 signed -> rdata 0xFFCD; byte load at 256 unsigned -> rdata 0x00AB.
REQ-024 Byte store 0x5A at addr 259 -> o_mem_addr=129, we_h=0, we_l=1, din_l=0x5A; a following word load at 258 returns low byte 0x5A with the high byte unchanged.
REQ-025 Word load at addr 0x101 -> no o_mem_en pulse, rsp err=1, rdata=0, o_err_cnt 0->1; 300 misaligned requests -> o_err_cnt=255.
REQ-026 Hold i_rsp_ready=0 for 3 cycles after o_rsp_valid -> response fields stable and o_req_ready=0 throughout; retirement on the 4th edge, and o_req_ready=1 on the next cycle.
REQ-027 Assert i_rst_n=0 during WAIT of a load -> o_rsp_valid never asserts and all outputs are 0 asynchronously; after release, a word load at 256 returns 0xABCD (RAM contents unaffected).
